reg_alias_table: RTL and testbench

Register alias table and physical-tag free list that answers the two rename query ports driven by the instruction resolver. Each cycle it returns the current physical tags for up to two instructions' source registers and offers up to two free destination tags (rn). Claimed tags are committed to the map on the clock edge. Tags return to the free list when instructions retire. It sits between the resolver and the reorder/commit logic, and is the responder side of the rename query protocol.

---
 rtl/reg_alias_table_if.sv | 42 ++++
 rtl/reg_alias_table.sv | 151 +++++++++++++++
 tb/tb_reg_alias_table.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_alias_table_if.sv
// Rename query bus between the instruction resolver / commit logic (master)
// and the register alias table (slave).
//   i_rs_1/i_rs_2/i_rd  : per-port architectural indices from the resolver
//   i_alloc             : port claims its offered o_rn for i_rd this edge
//   o_rs_1/o_rs_2       : mapped physical tags for the sources (0 = not renamed)
//   o_rn                : offered free tags (0 = unavailable)
//   i_retire_*          : commit-side tag release
//   i_flush / i_halt    : full squash / freeze allocation
//   o_free_count        : free tags available, o_panic: sticky protocol violation
interface reg_alias_table_if #(
    parameter int unsigned IDX_W = 5,
    parameter int unsigned TAG_W = 6
);
    logic [1:0][IDX_W-1:0] i_rs_1;
    logic [1:0][IDX_W-1:0] i_rs_2;
    logic [1:0][IDX_W-1:0] i_rd;
    logic [1:0]            i_alloc;
    logic [1:0][TAG_W-1:0] o_rs_1;
    logic [1:0][TAG_W-1:0] o_rs_2;
    logic [1:0][TAG_W-1:0] o_rn;
    logic [1:0]            i_retire_valid;
    logic [1:0][TAG_W-1:0] i_retire_tag;
    logic [1:0][IDX_W-1:0] i_retire_rd;
    logic                  i_flush;
    logic                  i_halt;
    logic [TAG_W-1:0]      o_free_count;
    logic                  o_panic;

    modport master (
        output i_rs_1, i_rs_2, i_rd, i_alloc,
        output i_retire_valid, i_retire_tag, i_retire_rd,
        output i_flush, i_halt,
        input  o_rs_1, o_rs_2, o_rn, o_free_count, o_panic
    );

    modport slave (
        input  i_rs_1, i_rs_2, i_rd, i_alloc,
        input  i_retire_valid, i_retire_tag, i_retire_rd,
        input  i_flush, i_halt,
        output o_rs_1, o_rs_2, o_rn, o_free_count, o_panic
    );
endinterface

// File: rtl/reg_alias_table.sv
// Register alias table plus physical-tag free list for a two-wide renamer.
// Ports:
//   i_clock   : rising-edge clock
//   i_reset_n : asynchronous active-low reset
//   bus       : rename query bus (slave side), see reg_alias_table_if
// Source lookups, offered tags and the free count are combinational from
// registered state; allocate, retire and flush update state on the clock edge.
module reg_alias_table #(
    parameter int unsigned ARCH_REGS = 32,
    parameter int unsigned TAG_W     = 6,
    parameter int unsigned FREE_TAGS = 63
) (
    input logic              i_clock,
    input logic              i_reset_n,
    reg_alias_table_if.slave bus
);

    localparam int unsigned DEPTH = 1 << TAG_W;

    typedef logic [TAG_W-1:0] tag_t;
    typedef tag_t             fl_t [DEPTH];

    localparam tag_t ONE = tag_t'(1);

    // Free list holding tags 1..FREE_TAGS in order, last slot unused.
    function automatic fl_t fl_init();
        fl_t f;
        for (int i = 0; i < DEPTH; i++) begin
            f[i] = (i < FREE_TAGS) ? tag_t'(i + 1) : '0;
        end
        return f;
    endfunction

    tag_t       map_q [ARCH_REGS];
    tag_t       map_d [ARCH_REGS];
    fl_t        fl_q;
    fl_t        fl_d;
    tag_t       head_q, head_d;
    tag_t       tail_q, tail_d;
    tag_t       count_q, count_d;
    logic       panic_q, panic_d;

    tag_t       head_p1;
    tag_t [1:0] rn;
    logic [1:0] acc;
    logic [1:0] bad_alloc;
    logic [TAG_W:0] pops;
    logic [TAG_W:0] fill;

    // Queries
    always_comb begin
        head_p1 = head_q + ONE;
        rn[0]   = (!bus.i_halt && count_q != '0)          ? fl_q[head_q]  : '0;
        rn[1]   = (!bus.i_halt && count_q >= tag_t'(2))   ? fl_q[head_p1] : '0;
        for (int k = 0; k < 2; k++) begin
            bus.o_rs_1[k] = map_q[bus.i_rs_1[k]];
            bus.o_rs_2[k] = map_q[bus.i_rs_2[k]];
            acc[k]        = bus.i_alloc[k] && !bus.i_halt && (rn[k] != '0);
            bad_alloc[k]  = bus.i_alloc[k] && !bus.i_halt && (rn[k] == '0);
        end
        bus.o_rn         = rn;
        bus.o_free_count = count_q;
        bus.o_panic      = panic_q;
    end

    // Next state
    always_comb begin
        map_d   = map_q;
        fl_d    = fl_q;
        head_d  = head_q;
        tail_d  = tail_q;
        panic_d = panic_q | (|bad_alloc);

        // Retire clears come first so a same-edge allocation overwrites them.
        for (int k = 0; k < 2; k++) begin
            if (bus.i_retire_valid[k] && bus.i_retire_tag[k] != '0 &&
                map_q[bus.i_retire_rd[k]] == bus.i_retire_tag[k]) begin
                map_d[bus.i_retire_rd[k]] = '0;
            end
        end
        // Port 1 written last so it wins when both ports name the same rd.
        for (int k = 0; k < 2; k++) begin
            if (acc[k]) begin
                map_d[bus.i_rd[k]] = rn[k];
            end
        end
        map_d[0] = '0;

        case (acc)
            2'b01:   head_d = head_q + ONE;
            2'b10: begin
                // Only the second offered tag was taken: slide the untaken
                // first tag into its slot so it stays at the new head.
                fl_d[head_p1] = fl_q[head_q];
                head_d        = head_q + ONE;
            end
            2'b11:   head_d = head_q + tag_t'(2);
            default: head_d = head_q;
        endcase

        pops = (TAG_W + 1)'(acc[0]) + (TAG_W + 1)'(acc[1]);
        fill = {1'b0, count_q} - pops;

        // Pops are applied before pushes, so a full list can still accept a
        // release on an edge that also allocates.
        for (int k = 0; k < 2; k++) begin
            if (bus.i_retire_valid[k] && bus.i_retire_tag[k] != '0) begin
                if (fill == (TAG_W + 1)'(FREE_TAGS)) begin
                    panic_d = 1'b1;
                end else begin
                    fl_d[tail_d] = bus.i_retire_tag[k];
                    tail_d       = tail_d + ONE;
                    fill         = fill + (TAG_W + 1)'(1);
                end
            end
        end
        count_d = fill[TAG_W-1:0];

        if (bus.i_flush) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                map_d[i] = '0;
            end
            fl_d    = fl_init();
            head_d  = '0;
            tail_d  = tag_t'(FREE_TAGS);
            count_d = tag_t'(FREE_TAGS);
            panic_d = panic_q;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                map_q[i] <= '0;
            end
            fl_q    <= fl_init();
            head_q  <= '0;
            tail_q  <= tag_t'(FREE_TAGS);
            count_q <= tag_t'(FREE_TAGS);
            panic_q <= 1'b0;
        end else begin
            map_q   <= map_d;
            fl_q    <= fl_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            panic_q <= panic_d;
        end
    end

endmodule

// File: tb/tb_reg_alias_table.sv
// Directed bench for reg_alias_table: reset, dual/same-rd allocation,
// retire, same-edge retire+allocate, flush, halt, exhaustion, pointer wrap,
// sticky panic and asynchronous mid-operation reset.
module tb_reg_alias_table;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    reg_alias_table_if bus ();

    reg_alias_table dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.i_rs_1         = '0;
        bus.i_rs_2         = '0;
        bus.i_rd           = '0;
        bus.i_alloc        = '0;
        bus.i_retire_valid = '0;
        bus.i_retire_tag   = '0;
        bus.i_retire_rd    = '0;
        bus.i_flush        = 1'b0;
        bus.i_halt         = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst_n = 1'b1;
        // Reset asserted mid-cycle takes effect without a clock edge
        #3 rst_n = 1'b0;
        #1 chk("reset_async_count", 32'(bus.o_free_count), 63);
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_rs_1[0] = 5'd5;
        bus.i_rs_2[1] = 5'd31;
        #1;
        chk("reset_rn0", 32'(bus.o_rn[0]), 1);
        chk("reset_rn1", 32'(bus.o_rn[1]), 2);
        chk("reset_count", 32'(bus.o_free_count), 63);
        chk("reset_rs1", 32'(bus.o_rs_1[0]), 0);
        chk("reset_rs2", 32'(bus.o_rs_2[1]), 0);
        chk("reset_panic", 32'(bus.o_panic), 0);

        // Dual allocate rd 5/6 -> tags 1/2
        tick();
        idle();
        bus.i_rd[0] = 5'd5;
        bus.i_rd[1] = 5'd6;
        bus.i_alloc = 2'b11;
        tick();
        idle();
        bus.i_rs_1[0] = 5'd5;
        bus.i_rs_1[1] = 5'd6;
        #1;
        chk("dual_map5", 32'(bus.o_rs_1[0]), 1);
        chk("dual_map6", 32'(bus.o_rs_1[1]), 2);
        chk("dual_rn0", 32'(bus.o_rn[0]), 3);
        chk("dual_rn1", 32'(bus.o_rn[1]), 4);
        chk("dual_count", 32'(bus.o_free_count), 61);

        // Same rd on both ports: port 1's tag (4) wins, both popped
        bus.i_rd[0] = 5'd7;
        bus.i_rd[1] = 5'd7;
        bus.i_alloc = 2'b11;
        tick();
        idle();
        bus.i_rs_2[0] = 5'd7;
        #1;
        chk("same_rd_map7", 32'(bus.o_rs_2[0]), 4);
        chk("same_rd_count", 32'(bus.o_free_count), 59);
        chk("same_rd_rn0", 32'(bus.o_rn[0]), 5);

        // Retire (tag 1, rd 5) with map[5] = 1 clears the entry
        bus.i_retire_valid[0] = 1'b1;
        bus.i_retire_tag[0]   = 6'd1;
        bus.i_retire_rd[0]    = 5'd5;
        tick();
        idle();
        bus.i_rs_1[0] = 5'd5;
        #1;
        chk("retire_map5", 32'(bus.o_rs_1[0]), 0);
        chk("retire_count", 32'(bus.o_free_count), 60);

        // Retire (tag 3, rd 6) with map[6] = 2 leaves the map alone
        bus.i_retire_valid[1] = 1'b1;
        bus.i_retire_tag[1]   = 6'd3;
        bus.i_retire_rd[1]    = 5'd6;
        tick();
        idle();
        bus.i_rs_1[1] = 5'd6;
        #1;
        chk("retire_nomatch_map6", 32'(bus.o_rs_1[1]), 2);
        chk("retire_nomatch_count", 32'(bus.o_free_count), 61);

        // map[5] <- 5
        bus.i_rd[0]    = 5'd5;
        bus.i_alloc[0] = 1'b1;
        tick();
        idle();
        bus.i_rs_1[0] = 5'd5;
        #1;
        chk("alloc_map5", 32'(bus.o_rs_1[0]), 5);
        chk("alloc_count", 32'(bus.o_free_count), 60);

        // Same edge: retire (tag 5, rd 5) and allocate rd 5 with tag 6
        bus.i_rd[0]           = 5'd5;
        bus.i_alloc[0]        = 1'b1;
        bus.i_retire_valid[0] = 1'b1;
        bus.i_retire_tag[0]   = 6'd5;
        bus.i_retire_rd[0]    = 5'd5;
        #1 chk("same_edge_rn0", 32'(bus.o_rn[0]), 6);
        tick();
        idle();
        bus.i_rs_1[0] = 5'd5;
        #1;
        chk("same_edge_map5", 32'(bus.o_rs_1[0]), 6);
        chk("same_edge_count", 32'(bus.o_free_count), 60);

        // Flush with alloc and retire on the same edge
        bus.i_rd[0]           = 5'd9;
        bus.i_rd[1]           = 5'd10;
        bus.i_alloc           = 2'b11;
        bus.i_retire_valid[0] = 1'b1;
        bus.i_retire_tag[0]   = 6'd6;
        bus.i_retire_rd[0]    = 5'd5;
        bus.i_flush           = 1'b1;
        tick();
        idle();
        bus.i_rs_1[0] = 5'd5;
        bus.i_rs_1[1] = 5'd7;
        bus.i_rs_2[0] = 5'd6;
        bus.i_rs_2[1] = 5'd9;
        #1;
        chk("flush_map5", 32'(bus.o_rs_1[0]), 0);
        chk("flush_map7", 32'(bus.o_rs_1[1]), 0);
        chk("flush_map6", 32'(bus.o_rs_2[0]), 0);
        chk("flush_map9", 32'(bus.o_rs_2[1]), 0);
        chk("flush_count", 32'(bus.o_free_count), 63);
        chk("flush_rn0", 32'(bus.o_rn[0]), 1);
        chk("flush_rn1", 32'(bus.o_rn[1]), 2);

        // Halt: no offers, allocation silently ignored
        bus.i_halt     = 1'b1;
        bus.i_rd[0]    = 5'd3;
        bus.i_alloc[0] = 1'b1;
        #1;
        chk("halt_rn0", 32'(bus.o_rn[0]), 0);
        chk("halt_rn1", 32'(bus.o_rn[1]), 0);
        tick();
        idle();
        bus.i_rs_1[0] = 5'd3;
        #1;
        chk("halt_map3", 32'(bus.o_rs_1[0]), 0);
        chk("halt_count", 32'(bus.o_free_count), 63);
        chk("halt_panic", 32'(bus.o_panic), 0);

        // Exhaustion: 31 dual allocations on rd 1/2
        for (int i = 0; i < 31; i++) begin
            idle();
            bus.i_rd[0] = 5'd1;
            bus.i_rd[1] = 5'd2;
            bus.i_alloc = 2'b11;
            tick();
        end
        idle();
        bus.i_rs_1[0] = 5'd1;
        bus.i_rs_1[1] = 5'd2;
        #1;
        chk("exhaust_count", 32'(bus.o_free_count), 1);
        chk("exhaust_rn0", 32'(bus.o_rn[0]), 63);
        chk("exhaust_rn1", 32'(bus.o_rn[1]), 0);
        chk("exhaust_map1", 32'(bus.o_rs_1[0]), 61);
        chk("exhaust_map2", 32'(bus.o_rs_1[1]), 62);

        bus.i_rd[0]    = 5'd3;
        bus.i_alloc[0] = 1'b1;
        tick();
        idle();
        bus.i_rs_1[0] = 5'd3;
        #1;
        chk("empty_count", 32'(bus.o_free_count), 0);
        chk("empty_rn0", 32'(bus.o_rn[0]), 0);
        chk("empty_rn1", 32'(bus.o_rn[1]), 0);
        chk("empty_map3", 32'(bus.o_rs_1[0]), 63);

        // Allocate with nothing offered: ignored, panic
        bus.i_rd[0]    = 5'd4;
        bus.i_alloc[0] = 1'b1;
        tick();
        idle();
        bus.i_rs_1[0] = 5'd4;
        #1;
        chk("illegal_panic", 32'(bus.o_panic), 1);
        chk("illegal_count", 32'(bus.o_free_count), 0);
        chk("illegal_map4", 32'(bus.o_rs_1[0]), 0);

        // Retire 10 then 20 across the 63->0 pointer wrap
        bus.i_retire_valid = 2'b11;
        bus.i_retire_tag[0] = 6'd10;
        bus.i_retire_tag[1] = 6'd20;
        bus.i_retire_rd[0]  = 5'd4;
        bus.i_retire_rd[1]  = 5'd4;
        tick();
        idle();
        #1;
        chk("wrap_count", 32'(bus.o_free_count), 2);
        chk("wrap_rn0", 32'(bus.o_rn[0]), 10);
        chk("wrap_rn1", 32'(bus.o_rn[1]), 20);

        // Consume both while releasing 30
        bus.i_rd[0]           = 5'd8;
        bus.i_rd[1]           = 5'd9;
        bus.i_alloc           = 2'b11;
        bus.i_retire_valid[0] = 1'b1;
        bus.i_retire_tag[0]   = 6'd30;
        bus.i_retire_rd[0]    = 5'd4;
        tick();
        idle();
        bus.i_rs_1[0] = 5'd8;
        bus.i_rs_1[1] = 5'd9;
        #1;
        chk("wrap_map8", 32'(bus.o_rs_1[0]), 10);
        chk("wrap_map9", 32'(bus.o_rs_1[1]), 20);
        chk("wrap2_count", 32'(bus.o_free_count), 1);
        chk("wrap2_rn0", 32'(bus.o_rn[0]), 30);

        // Matching retire on rd 1 (map[1] = 61)
        bus.i_retire_valid[1] = 1'b1;
        bus.i_retire_tag[1]   = 6'd61;
        bus.i_retire_rd[1]    = 5'd1;
        tick();
        idle();
        bus.i_rs_2[0] = 5'd1;
        #1;
        chk("retire61_map1", 32'(bus.o_rs_2[0]), 0);
        chk("retire61_rn1", 32'(bus.o_rn[1]), 61);

        // Flush keeps panic
        bus.i_flush = 1'b1;
        tick();
        idle();
        #1;
        chk("flush_panic_sticky", 32'(bus.o_panic), 1);
        chk("flush2_count", 32'(bus.o_free_count), 63);

        // Mid-operation asynchronous reset
        bus.i_rd[0] = 5'd11;
        bus.i_rd[1] = 5'd12;
        bus.i_alloc = 2'b11;
        tick();
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_count", 32'(bus.o_free_count), 63);
        chk("midreset_panic", 32'(bus.o_panic), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Release while full is dropped and flags panic
        bus.i_retire_valid[0] = 1'b1;
        bus.i_retire_tag[0]   = 6'd5;
        bus.i_retire_rd[0]    = 5'd0;
        tick();
        idle();
        #1;
        chk("full_push_panic", 32'(bus.o_panic), 1);
        chk("full_push_count", 32'(bus.o_free_count), 63);
        chk("full_push_rn0", 32'(bus.o_rn[0]), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
